adder_inverse_serial: RTL

- Bit-serial recovery unit: given an 8-bit modular sum and one addend, recovers the other addend, diff = sum - addend mod 2^WIDTH.
- Undoes the combinational 8-bit adder circuit; used to check round trips of adder netlists in the evaluation flow.
- Processes one bit per clock, LSB first, using a full-subtractor cell (XOR3 + borrow majority), matching the LUT-cell granularity of the adder netlists.
- Valid/ready handshake on both input and output.

---
 rtl/adder_inverse_serial.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/adder_inverse_serial.sv
`default_nettype none
// ============================================================================
// Module   : adder_inverse_serial
// Purpose  : Bit-serial recovery of one addend from a modular sum.
//            Computes diff = sum_in - addend_in mod 2^WIDTH, one bit per
//            clock, LSB first, using a single full-subtractor cell
//            (XOR3 for the difference bit, majority-style borrow).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      operand / result width in bits (2..32)
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operands presented on sum_in / addend_in
//   in_ready   block is idle and can accept operands
//   sum_in     modular sum (minuend)
//   addend_in  known addend (subtrahend)
//   out_valid  result available on diff_out / borrow_out / zero_out
//   out_ready  consumer takes the result
//   diff_out   recovered addend, sum_in - addend_in mod 2^WIDTH
//   borrow_out final borrow, 1 iff sum_in < addend_in (addition wrapped)
//   zero_out   diff_out == 0
// ============================================================================
module adder_inverse_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] addend_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             zero_out
);

  // Counter must be able to hold WIDTH itself (the value it reaches on the
  // final bit edge), hence WIDTH+1 states.
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Value of the counter while the last (MSB) bit is being processed.
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  state_t             state_q,      state_d;
  logic [WIDTH-1:0]   sum_sr_q,     sum_sr_d;
  logic [WIDTH-1:0]   add_sr_q,     add_sr_d;
  logic [WIDTH-1:0]   diff_sr_q,    diff_sr_d;
  logic               borrow_q,     borrow_d;
  logic [CNT_W-1:0]   count_q,      count_d;
  logic [WIDTH-1:0]   diff_out_q,   diff_out_d;
  logic               borrow_out_q, borrow_out_d;
  logic               zero_out_q,   zero_out_d;

  // --------------------------------------------------------------------------
  // Full-subtractor cell on the current LSBs
  // --------------------------------------------------------------------------
  logic             bit_s;
  logic             bit_b;
  logic             bit_d;
  logic             borrow_nxt;
  logic [WIDTH-1:0] diff_nxt;

  always_comb begin
    bit_s      = sum_sr_q[0];
    bit_b      = add_sr_q[0];
    bit_d      = bit_s ^ bit_b ^ borrow_q;
    // Borrow out when the minuend bit is 0 and the subtrahend bit is 1, or
    // when the two bits are equal and a borrow is already pending.
    borrow_nxt = (~bit_s & bit_b) | (~(bit_s ^ bit_b) & borrow_q);
    // Difference bits enter at the MSB and shift right, so after WIDTH
    // steps the first (LSB) bit has arrived at position 0.
    diff_nxt   = {bit_d, diff_sr_q[WIDTH-1:1]};
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    sum_sr_d     = sum_sr_q;
    add_sr_d     = add_sr_q;
    diff_sr_d    = diff_sr_q;
    borrow_d     = borrow_q;
    count_d      = count_q;
    diff_out_d   = diff_out_q;
    borrow_out_d = borrow_out_q;
    zero_out_d   = zero_out_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_sr_d  = sum_in;
          add_sr_d  = addend_in;
          diff_sr_d = '0;
          borrow_d  = 1'b0;
          count_d   = '0;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        // in_valid is deliberately not looked at here: no capture while busy.
        sum_sr_d  = sum_sr_q >> 1;
        add_sr_d  = add_sr_q >> 1;
        diff_sr_d = diff_nxt;
        borrow_d  = borrow_nxt;
        count_d   = count_q + 1'b1;
        if (count_q == C_LAST_BIT) begin
          // Result registers load on the same edge the FSM enters DONE, so
          // they are already stable in the first cycle out_valid is high.
          diff_out_d   = diff_nxt;
          borrow_out_d = borrow_nxt;
          zero_out_d   = (diff_nxt == '0);
          state_d      = DONE;
        end
      end

      DONE: begin
        // Result registers are untouched here, which holds them stable
        // under backpressure.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sum_sr_q     <= '0;
      add_sr_q     <= '0;
      diff_sr_q    <= '0;
      borrow_q     <= 1'b0;
      count_q      <= '0;
      diff_out_q   <= '0;
      borrow_out_q <= 1'b0;
      zero_out_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_sr_q     <= sum_sr_d;
      add_sr_q     <= add_sr_d;
      diff_sr_q    <= diff_sr_d;
      borrow_q     <= borrow_d;
      count_q      <= count_d;
      diff_out_q   <= diff_out_d;
      borrow_out_q <= borrow_out_d;
      zero_out_q   <= zero_out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: handshake flags decode directly from the state register, data
  // comes straight from flops; no input reaches an output combinationally.
  // --------------------------------------------------------------------------
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff_out   = diff_out_q;
  assign borrow_out = borrow_out_q;
  assign zero_out   = zero_out_q;

endmodule
`default_nettype wire
